// File: rtl/tone_sequencer.sv
// tone_sequencer: buffered note player. Queues note commands in a small FIFO and plays
// each as a square wave at its pitch for its duration, followed by a silent gap.
module tone_sequencer #(
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_DIV   = 50000,
  parameter int GAP_TICKS  = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_note,
  input  logic [7:0] in_dur,
  output logic       in_ready,
  input  logic       stop,
  output logic       tone_out,
  output logic [3:0] cur_note,
  output logic       busy,
  output logic       note_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(CLK_HZ / (2 * 262) + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    GAP_LAST  = 8'(GAP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  // Half-period in clk cycles; zero marks a rest code.
  function automatic logic [HW-1:0] half_of(input logic [3:0] code);
    case (code)
      4'd1:    half_of = HW'(CLK_HZ / (2 * 262));
      4'd2:    half_of = HW'(CLK_HZ / (2 * 294));
      4'd3:    half_of = HW'(CLK_HZ / (2 * 330));
      4'd4:    half_of = HW'(CLK_HZ / (2 * 349));
      4'd5:    half_of = HW'(CLK_HZ / (2 * 392));
      4'd6:    half_of = HW'(CLK_HZ / (2 * 440));
      4'd7:    half_of = HW'(CLK_HZ / (2 * 494));
      4'd8:    half_of = HW'(CLK_HZ / (2 * 523));
      default: half_of = '0;
    endcase
  endfunction

  state_t          state_reg;
  logic [11:0]     fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg, count_next;
  logic [7:0]      dur_reg, tick_reg;
  logic [HW-1:0]   half_reg, tone_cnt_reg;
  logic [PW-1:0]   presc_reg;
  logic [11:0]     head;
  logic            full, do_write, do_pop;

  assign full     = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign in_ready = stop | ~full;
  assign do_write = in_valid & ~full & ~stop;
  assign do_pop   = (state_reg == LOAD) & ~stop;
  assign head     = fifo_mem[rd_ptr_reg];
  assign busy     = (state_reg != IDLE) | (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    if (do_write && !do_pop)
      count_next = count_reg + 1'b1;
    else if (!do_write && do_pop)
      count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_write)
      fifo_mem[wr_ptr_reg] <= {in_note, in_dur};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      dur_reg      <= '0;
      tick_reg     <= '0;
      half_reg     <= '0;
      tone_cnt_reg <= '0;
      presc_reg    <= '0;
      tone_out     <= 1'b0;
      cur_note     <= 4'd0;
      note_done    <= 1'b0;
    end else if (stop) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      tone_out   <= 1'b0;
      cur_note   <= 4'd0;
      note_done  <= 1'b0;
    end else begin
      note_done <= 1'b0;
      count_reg <= count_next;
      if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case (state_reg)
        IDLE: if (count_reg != '0) state_reg <= LOAD;
        LOAD: begin
          dur_reg      <= head[7:0];
          half_reg     <= half_of(head[11:8]);
          presc_reg    <= '0;
          tick_reg     <= '0;
          tone_cnt_reg <= '0;
          tone_out     <= 1'b0;
          if (head[7:0] == 8'd0) begin
            note_done <= 1'b1;
            state_reg <= (count_next != '0) ? LOAD : IDLE;
          end else begin
            cur_note  <= head[11:8];
            state_reg <= PLAY;
          end
        end
        PLAY: begin
          if (half_reg != '0) begin
            if (tone_cnt_reg == half_reg - 1'b1) begin
              tone_cnt_reg <= '0;
              tone_out     <= ~tone_out;
            end else begin
              tone_cnt_reg <= tone_cnt_reg + 1'b1;
            end
          end
          // The final PLAY cycle overrides any toggle so the gap starts silent.
          if (presc_reg == TICK_LAST) begin
            presc_reg <= '0;
            if (tick_reg == dur_reg - 8'd1) begin
              tick_reg <= '0;
              tone_out <= 1'b0;
              cur_note <= 4'd0;
              if (GAP_TICKS == 0) begin
                note_done <= 1'b1;
                state_reg <= (count_next != '0) ? LOAD : IDLE;
              end else begin
                state_reg <= GAP;
              end
            end else begin
              tick_reg <= tick_reg + 8'd1;
            end
          end else begin
            presc_reg <= presc_reg + 1'b1;
          end
        end
        GAP: begin
          if (presc_reg == TICK_LAST) begin
            presc_reg <= '0;
            if (tick_reg == GAP_LAST) begin
              tick_reg  <= '0;
              note_done <= 1'b1;
              state_reg <= (count_next != '0) ? LOAD : IDLE;
            end else begin
              tick_reg <= tick_reg + 8'd1;
            end
          end else begin
            presc_reg <= presc_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed and random stimulus checked cycle by cycle against a
// timeline model of the note queue (LOAD, PLAY, GAP and done step derived from the rules).
module tb_tone_sequencer;
  localparam int CLK_HZ = 8800;
  localparam int TD     = 4;
  localparam int G      = 1;
  localparam int DEPTH  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_note = 4'd0;
  logic [7:0] in_dur = 8'd0;
  logic       stop = 1'b0;
  logic       in_ready, tone_out, busy, note_done;
  logic [3:0] cur_note;

  tone_sequencer #(.CLK_HZ(CLK_HZ), .TICK_DIV(TD), .GAP_TICKS(G), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_note(in_note), .in_dur(in_dur),
    .in_ready(in_ready), .stop(stop), .tone_out(tone_out), .cur_note(cur_note),
    .busy(busy), .note_done(note_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int freq [16] = '{0, 262, 294, 330, 349, 392, 440, 494, 523, 0, 0, 0, 0, 0, 0, 0};

  // Model: queue of commands still in the FIFO and the timeline of the current note.
  logic [11:0] q [$];
  bit act, last_acc, exp_done;
  int st, nd, nc, cyc, prev_size, n_done;

  function automatic int half(input int code);
    return (freq[code] == 0) ? 0 : CLK_HZ / (2 * freq[code]);
  endfunction

  function automatic int note_len(input int d);
    return (d == 0) ? 1 : d * TD + G * TD + 1;
  endfunction

  function automatic int phase();
    int k;
    if (!act) return 0;
    k = cyc - st;
    if (k == 0) return 1;
    if (k <= nd * TD) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    q.delete();
    act = 0; last_acc = 0; exp_done = 0; prev_size = 0;
  endtask

  task automatic model_edge();
    logic [11:0] tmp;
    cyc++;
    exp_done = 0;
    last_acc = 0;
    if (stop) begin
      model_reset();
      return;
    end
    last_acc = in_valid && (q.size() < DEPTH);
    if (act && (cyc - 1 == st)) begin
      tmp = q.pop_front();
      nc = int'(tmp[11:8]);
      nd = int'(tmp[7:0]);
    end
    if (last_acc) q.push_back({in_note, in_dur});
    if (act && (cyc - st == note_len(nd))) begin
      exp_done = 1;
      if (q.size() > 0) st = cyc;
      else act = 0;
    end else if (!act && prev_size > 0) begin
      act = 1;
      st = cyc;
    end
    prev_size = q.size();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_outputs();
    int k, h;
    logic [7:0] et, ec;
    et = 8'd0;
    ec = 8'd0;
    if (act) begin
      k = cyc - st;
      if (nd > 0 && k >= 1 && k <= nd * TD) begin
        ec = 8'(nc);
        h = half(nc);
        if (h > 0) et = 8'(((k - 1) / h) % 2);
      end
    end
    chk("tone_out", 8'(tone_out), et);
    chk("cur_note", 8'(cur_note), ec);
    chk("note_done", 8'(note_done), 8'(exp_done));
    chk("busy", 8'(busy), 8'(act || q.size() > 0));
    chk("in_ready", 8'(in_ready), 8'(stop || q.size() < DEPTH));
    if (note_done === 1'b1) begin
      n_done++;
      $display("cycle %0d: note complete (%0d total)", cyc, n_done);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send(input logic [3:0] n, input logic [7:0] d);
    in_valid = 1'b1;
    in_note = n;
    in_dur = d;
    for (int i = 0; i < 300; i++) begin
      step();
      if (last_acc) break;
    end
    $display("cycle %0d: command note=%0d dur=%0d accepted=%0d", cyc, n, d, last_acc);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && (act || q.size() > 0); i++) step();
    step();
    chk("drained_busy", 8'(busy), 8'd0);
  endtask

  initial begin
    #5000000;
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc = 0; n_done = 0; st = 0; nd = 0; nc = 0;
    model_reset();

    // Reset held with a pending command: nothing is accepted, outputs silent.
    in_valid = 1'b1; in_note = 4'd6; in_dur = 8'd5;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tone", 8'(tone_out), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_done", 8'(note_done), 8'd0);
      chk("rst_cur", 8'(cur_note), 8'd0);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) step();

    // Single pitched note.
    send(4'd6, 8'd5);
    drain(100);

    // Rest, then zero-duration note.
    send(4'd0, 8'd3);
    send(4'd1, 8'd0);
    drain(100);

    // FIFO full: long note, then five back-to-back commands.
    send(4'd5, 8'd10);
    send(4'd1, 8'd1);
    send(4'd8, 8'd2);
    send(4'd3, 8'd1);
    send(4'd12, 8'd1);
    send(4'd7, 8'd2);
    drain(400);

    // Stop mid-note with entries queued; a write in the stop cycle is discarded.
    send(4'd3, 8'd8);
    send(4'd2, 8'd2);
    send(4'd4, 8'd2);
    send(4'd6, 8'd2);
    for (int i = 0; i < 100 && phase() != 2; i++) step();
    repeat (3) step();
    stop = 1'b1; in_valid = 1'b1; in_note = 4'd5; in_dur = 8'd4;
    step();
    stop = 1'b0; in_valid = 1'b0;
    chk("stop_busy", 8'(busy), 8'd0);
    chk("stop_tone", 8'(tone_out), 8'd0);
    repeat (5) step();

    // Asynchronous reset during the gap.
    send(4'd6, 8'd2);
    for (int i = 0; i < 100 && phase() != 3; i++) step();
    chk("pre_rst_busy", 8'(busy), 8'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_tone", 8'(tone_out), 8'd0);
    chk("arst_cur", 8'(cur_note), 8'd0);
    chk("arst_busy", 8'(busy), 8'd0);
    chk("arst_done", 8'(note_done), 8'd0);
    chk("arst_ready", 8'(in_ready), 8'd1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (4) step();

    // Random traffic with occasional stop.
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom % 3) == 0;
      in_note = 4'($urandom_range(0, 15));
      in_dur = 8'($urandom_range(0, 3));
      stop = ($urandom % 150) == 0;
      step();
    end
    in_valid = 1'b0;
    stop = 1'b0;
    drain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
